// File: rtl/fast_corner_scheduler.sv
// fast_corner_scheduler
// Sits between the FAST corner detector and the descriptor stage. Tracks
// pixel coordinates, queues detected corners as (x, y, type), enforces a
// per-frame corner budget and closes each frame with a done pulse plus
// accepted/dropped statistics.
// Optional feature macro: FAST_ADAPTIVE_THRESH_EN (adaptive next-frame threshold).
//
// state  | meaning
// IDLE   | no frame in progress
// ACTIVE | frame in progress, corners queued
// FLUSH  | frame ended, draining the old-frame entries (pending count)
// DONE   | one-cycle frame close: done pulse, statistics load

module fast_corner_scheduler #(
    parameter int P_COORD_W     = 11,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_MAX_CORNERS = 500,
    parameter int P_MIN_CORNERS = 100,
    parameter int P_THRESH_INIT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_image_vs,
    input  logic                 i_image_hs,
    input  logic                 i_image_en,
    input  logic [7:0]           i_image_data,
    output logic                 o_corner_valid,
    input  logic                 i_corner_ready,
    output logic [P_COORD_W-1:0] o_corner_x,
    output logic [P_COORD_W-1:0] o_corner_y,
    output logic [1:0]           o_corner_type,
    output logic                 o_frame_done,
    output logic [15:0]          o_corner_count,
    output logic [15:0]          o_drop_count,
    output logic [7:0]           o_threshold
);

    localparam int P_AW  = $clog2(P_FIFO_DEPTH);
    localparam int ENT_W = 2 * P_COORD_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic                 r_vs_d, r_hs_d;
    logic                 w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
    logic [P_COORD_W-1:0] r_x, r_y, w_x_cur, w_y_cur;
    logic [15:0]          r_acc, r_drop, w_acc_cur, w_drop_cur, w_acc_nxt, w_drop_nxt;
    logic [15:0]          r_snap_acc, r_snap_drop;
    logic [ENT_W-1:0]     r_mem [P_FIFO_DEPTH];
    logic [P_AW:0]        r_wr_ptr, r_rd_ptr, r_count, w_occ, r_pending;
    logic                 w_corner, w_full, w_push, w_drop, w_load, w_hs_out;
    logic                 r_vs_pend;
    logic [ENT_W-1:0]     w_head;

    assign w_vs_rise = i_image_vs & ~r_vs_d;
    assign w_vs_fall = ~i_image_vs & r_vs_d;
    assign w_hs_rise = i_image_hs & ~r_hs_d;
    assign w_hs_fall = ~i_image_hs & r_hs_d;

    // A line/frame start in the same cycle as a pixel makes that pixel coordinate 0.
    assign w_x_cur = w_hs_rise ? '0 : r_x;
    assign w_y_cur = w_vs_rise ? '0 : r_y;

    assign w_acc_cur  = w_vs_rise ? 16'd0 : r_acc;
    assign w_drop_cur = w_vs_rise ? 16'd0 : r_drop;

    // The output register counts toward capacity; a same-cycle pop frees nothing.
    assign w_occ    = r_count + {{P_AW{1'b0}}, o_corner_valid};
    assign w_full   = (w_occ >= (P_AW + 1)'(P_FIFO_DEPTH));
    assign w_corner = i_image_en && (i_image_data == 8'd1 || i_image_data == 8'd2);
    assign w_push   = w_corner && (w_acc_cur < 16'(P_MAX_CORNERS)) && !w_full;
    assign w_drop   = w_corner && !w_push;

    assign w_acc_nxt  = w_acc_cur + {15'd0, w_push};
    assign w_drop_nxt = (w_drop && w_drop_cur != 16'hFFFF) ? w_drop_cur + 16'd1 : w_drop_cur;

    assign w_hs_out = o_corner_valid && i_corner_ready;
    assign w_load   = (r_count != '0) && (!o_corner_valid || i_corner_ready);
    assign w_head   = r_mem[r_rd_ptr[P_AW-1:0]];

    assign o_frame_done = (r_state == S_DONE);

    // Edge detectors and pixel coordinate counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_d <= 1'b0;
            r_hs_d <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_vs_d <= i_image_vs;
            r_hs_d <= i_image_hs;
            r_x    <= (i_image_en && w_x_cur != '1) ? w_x_cur + 1'b1 : w_x_cur;
            r_y    <= (w_hs_fall && w_y_cur != '1) ? w_y_cur + 1'b1 : w_y_cur;
        end
    end

    // Per-frame accepted/drop counters and their end-of-frame snapshots.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_drop      <= '0;
            r_snap_acc  <= '0;
            r_snap_drop <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_drop <= w_drop_nxt;
            if (w_vs_fall) begin
                r_snap_acc  <= w_acc_nxt;
                r_snap_drop <= w_drop_nxt;
            end
        end
    end

    // Corner storage; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[P_AW-1:0]] <= {w_x_cur, w_y_cur, i_image_data[1:0]};
    end

    // FIFO pointers/occupancy and the output holding register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            o_corner_valid <= 1'b0;
            o_corner_x     <= '0;
            o_corner_y     <= '0;
            o_corner_type  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{P_AW{1'b0}}, w_push} - {{P_AW{1'b0}}, w_load};
            if (w_load) begin
                o_corner_valid <= 1'b1;
                {o_corner_x, o_corner_y, o_corner_type} <= w_head;
            end else if (w_hs_out) begin
                o_corner_valid <= 1'b0;
            end
        end
    end

    // State register, old-frame pending count, early-new-frame flag and statistics.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_pending      <= '0;
            r_vs_pend      <= 1'b0;
            o_corner_count <= '0;
            o_drop_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_ACTIVE && w_vs_fall)
                r_pending <= w_occ + {{P_AW{1'b0}}, w_push} - {{P_AW{1'b0}}, w_hs_out};
            else if (r_state == S_FLUSH && w_hs_out && r_pending != '0)
                r_pending <= r_pending - 1'b1;
            if (r_state == S_DONE)
                r_vs_pend <= 1'b0;
            else if (r_state == S_FLUSH && w_vs_rise)
                r_vs_pend <= 1'b1;
            if (r_state == S_DONE) begin
                o_corner_count <= r_snap_acc;
                o_drop_count   <= r_snap_drop;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_vs_rise) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_vs_fall) w_state_nxt = S_FLUSH;
            S_FLUSH:  if (r_pending == '0 || (r_pending == 1 && w_hs_out))
                          w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = (r_vs_pend || w_vs_rise) ? S_ACTIVE : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

`ifdef FAST_ADAPTIVE_THRESH_EN
    // Raise the threshold after a lossy frame, lower it after a sparse one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_threshold <= 8'(P_THRESH_INIT);
        end else if (r_state == S_DONE) begin
            if (r_snap_drop != 16'd0) begin
                if (o_threshold != 8'hFF)
                    o_threshold <= o_threshold + 8'd1;
            end else if (r_snap_acc < 16'(P_MIN_CORNERS)) begin
                if (o_threshold > 8'd1)
                    o_threshold <= o_threshold - 8'd1;
            end
        end
    end
`else
    assign o_threshold = 8'(P_THRESH_INIT);
`endif

endmodule

// File: tb/tb_fast_corner_scheduler.sv
// Directed bench for fast_corner_scheduler: a default instance plus a
// budget-limited instance (P_MAX_CORNERS=3) sharing the same stimulus.

module tb_fast_corner_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0, hs = 1'b0, en = 1'b0, ready = 1'b0;
    logic [7:0]  data = 8'd0;

    logic        valid, done, b_valid, b_done;
    logic [10:0] cx, cy, b_x, b_y;
    logic [1:0]  ctype, b_type;
    logic [15:0] ccount, dcount, b_ccount, b_dcount;
    logic [7:0]  thr, b_thr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fast_corner_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_image_vs(vs), .i_image_hs(hs),
        .i_image_en(en), .i_image_data(data), .o_corner_valid(valid),
        .i_corner_ready(ready), .o_corner_x(cx), .o_corner_y(cy),
        .o_corner_type(ctype), .o_frame_done(done), .o_corner_count(ccount),
        .o_drop_count(dcount), .o_threshold(thr)
    );

    fast_corner_scheduler #(.P_MAX_CORNERS(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_image_vs(vs), .i_image_hs(hs),
        .i_image_en(en), .i_image_data(data), .o_corner_valid(b_valid),
        .i_corner_ready(ready), .o_corner_x(b_x), .o_corner_y(b_y),
        .o_corner_type(b_type), .o_frame_done(b_done), .o_corner_count(b_ccount),
        .o_drop_count(b_dcount), .o_threshold(b_thr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the default instance pulses frame_done (bounded).
    task automatic wait_done(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // One line of n pixels; every pixel carries corner value cval.
    task automatic corner_line(input int n, input logic [7:0] cval);
        hs = 1'b1; en = 1'b1; data = cval;
        for (int i = 0; i < n; i++) tick();
        hs = 1'b0; en = 1'b0; data = 8'd0;
        tick();
    endtask

    logic [10:0] exp_x [6];
    logic [1:0]  exp_t [6];
    int          rcv, n;
    logic        seen_a, seen_b, seen_bad;
    logic [7:0]  exp_thr;

    initial begin
        // reset state
        tick(); tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_xyt", {cx, cy, 8'd0, ctype}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_counts", {ccount, dcount}, 32'd0);
        check("rst_thr", {24'd0, thr}, 32'd3);
        rst = 1'b0;
        tick();

        // single corner at (5,2), ready high
        ready = 1'b1;
        vs = 1'b1; tick();
        corner_line(8, 8'd0);
        corner_line(8, 8'd0);
        hs = 1'b1; en = 1'b1; data = 8'd0;
        for (int i = 0; i < 5; i++) tick();
        data = 8'd1; tick();
        check("single_lat_k", {31'd0, valid}, 32'd0);
        data = 8'd0; tick();
        check("single_lat_k1", {31'd0, valid}, 32'd1);
        check("single_entry", {cx, cy, 8'd0, ctype}, {11'd5, 11'd2, 8'd0, 2'd1});
        hs = 1'b0; en = 1'b0; tick();
        vs = 1'b0; tick();
        check("single_flush", {31'd0, done}, 32'd0);
        tick();
        check("single_done", {31'd0, done}, 32'd1);
        tick();
        check("single_done_1cyc", {31'd0, done}, 32'd0);
        check("single_counts", {ccount, dcount}, {16'd1, 16'd0});

        // backpressure: 20 corners with ready low
        ready = 1'b0;
        vs = 1'b1; tick();
        hs = 1'b1; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data = (i % 2 == 1) ? 8'd2 : 8'd1;
            tick();
        end
        hs = 1'b0; en = 1'b0; data = 8'd0; tick();
        check("bp_head", {cx, cy, 8'd0, ctype}, {11'd0, 11'd0, 8'd0, 2'd1});
        tick(); tick(); tick();
        check("bp_head_hold", {valid, cx, cy, 7'd0, ctype}, {1'b1, 11'd0, 11'd0, 7'd0, 2'd1});
        ready = 1'b1;
        rcv = 0; n = 0;
        while (rcv < 16 && n < 40) begin
            if (valid) begin
                check("bp_order", {19'd0, cx, ctype}, {19'd0, 11'(rcv), (rcv % 2 == 1) ? 2'd2 : 2'd1});
                rcv++;
            end
            tick();
            n++;
        end
        check("bp_received", rcv, 16);
        check("bp_empty", {31'd0, valid}, 32'd0);
        vs = 1'b0;
        wait_done("bp_done", 20);
        tick();
        check("bp_counts", {ccount, dcount}, {16'd16, 16'd4});

        // budget: 5 corners, ready high, budget-limited instance keeps 3
        vs = 1'b1; tick();
        corner_line(5, 8'd1);
        vs = 1'b0;
        seen_a = 1'b0; seen_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen_a = 1'b1;
            if (b_done) seen_b = 1'b1;
        end
        check("budget_done_seen", {30'd0, seen_a, seen_b}, 32'd3);
        check("budget_counts_b", {b_ccount, b_dcount}, {16'd3, 16'd2});
        check("budget_counts_a", {ccount, dcount}, {16'd5, 16'd0});

        // flush: 4 queued at vs fall, ready low 10 cycles, new frame during FLUSH
        ready = 1'b0;
        vs = 1'b1; tick();
        corner_line(4, 8'd1);
        vs = 1'b0;
        seen_bad = 1'b0;
        tick();
        if (done) seen_bad = 1'b1;
        tick(); tick();
        if (done) seen_bad = 1'b1;
        vs = 1'b1; tick();
        hs = 1'b1; en = 1'b1; data = 8'd2;
        tick(); tick();
        hs = 1'b0; en = 1'b0; data = 8'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) seen_bad = 1'b1;
        end
        check("flush_no_early_done", {31'd0, seen_bad}, 32'd0);
        check("flush_head_hold", {valid, 9'd0, cx, 9'd0, ctype}, {1'b1, 9'd0, 11'd0, 9'd0, 2'd1});
        exp_x[0] = 11'd0; exp_x[1] = 11'd1; exp_x[2] = 11'd2;
        exp_x[3] = 11'd3; exp_x[4] = 11'd0; exp_x[5] = 11'd1;
        exp_t[0] = 2'd1; exp_t[1] = 2'd1; exp_t[2] = 2'd1;
        exp_t[3] = 2'd1; exp_t[4] = 2'd2; exp_t[5] = 2'd2;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("flush_entry", {valid, 18'd0, cx, ctype}, {1'b1, 18'd0, exp_x[k], exp_t[k]});
            tick();
            check("flush_done_timing", {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
        end
        check("flush_counts", {ccount, dcount}, {16'd4, 16'd0});
        vs = 1'b0;
        wait_done("flush_newframe_done", 20);
        tick();
        check("flush_newframe_counts", {ccount, dcount}, {16'd2, 16'd0});

        // async reset mid-frame with 6 entries queued
        ready = 1'b0;
        vs = 1'b1; tick();
        corner_line(6, 8'd1);
        check("rstmid_valid_before", {31'd0, valid}, 32'd1);
        #2;
        rst = 1'b1;
        vs = 1'b0;
        #1;
        check("rstmid_valid_now", {31'd0, valid}, 32'd0);
        check("rstmid_counts", {ccount, dcount}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        ready = 1'b1;
        seen_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || valid) seen_bad = 1'b1;
        end
        check("rstmid_no_done", {31'd0, seen_bad}, 32'd0);
        check("rstmid_thr", {24'd0, thr}, 32'd3);

        // threshold: frame with 2 drops, then a frame of 50 corners
        ready = 1'b0;
        vs = 1'b1; tick();
        corner_line(18, 8'd1);
        ready = 1'b1;
        vs = 1'b0;
        wait_done("thr1_done", 40);
        tick();
        check("thr1_counts", {ccount, dcount}, {16'd16, 16'd2});
`ifdef FAST_ADAPTIVE_THRESH_EN
        exp_thr = 8'd4;
`else
        exp_thr = 8'd3;
`endif
        check("thr1_value", {24'd0, thr}, {24'd0, exp_thr});
        vs = 1'b1; tick();
        corner_line(50, 8'd2);
        vs = 1'b0;
        wait_done("thr2_done", 20);
        tick();
        check("thr2_counts", {ccount, dcount}, {16'd50, 16'd0});
        exp_thr = 8'd3;
        check("thr2_value", {24'd0, thr}, {24'd0, exp_thr});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fast_corner_scheduler.md
# fast_corner_scheduler

Sequencer between the FAST corner-detection stage and the downstream descriptor stage. It tracks pixel coordinates from the FAST result stream, queues detected corners as (x, y, type) entries in a small FIFO, and enforces a per-frame corner budget. Queued corners are handed off over a valid/ready handshake. Each frame is closed with a completion pulse and statistics, and the detection threshold for the next frame can optionally be set adaptively.

## Interface

Parameters:
- P_COORD_W, 11: coordinate width.
- P_FIFO_DEPTH, 16: corner FIFO depth; power of 2.
- P_MAX_CORNERS, 500: accepted-corner budget per frame.
- P_MIN_CORNERS, 100: adaptive lower target.
- P_THRESH_INIT, 3: threshold reset value.

Ports:
- i_clk, in, 1: the single clock.
- i_rst, in, 1: reset; asynchronous and active-high.
- i_image_vs, in, 1: high for the whole frame.
- i_image_hs, in, 1: high for the whole line.
- i_image_en, in, 1: pixel valid.
- i_image_data, in, 8: FAST result; 0 none, 1 bright, 2 dark, other values none.
- o_corner_valid, out, 1: corner entry available.
- i_corner_ready, in, 1: downstream accepts the entry.
- o_corner_x, out, P_COORD_W: corner x coordinate.
- o_corner_y, out, P_COORD_W: corner y coordinate.
- o_corner_type, out, 2: 1 bright, 2 dark.
- o_frame_done, out, 1: one-cycle pulse when the frame is complete.
- o_corner_count, out, 16: corners accepted in the last completed frame.
- o_drop_count, out, 16: corners dropped in the last completed frame.
- o_threshold, out, 8: threshold to apply to the next frame.

## Operation

Coordinates:
- x clears on a rising edge of i_image_hs and increments after each i_image_en.
- y clears on a rising edge of i_image_vs and increments on each falling edge of i_image_hs.
- The first pixel of a frame is (0,0).
- Both counters saturate at 2^P_COORD_W-1.

Push rule:
- A push occurs when i_image_en is high, i_image_data is 1 or 2, the frame accepted count is below P_MAX_CORNERS, and the FIFO is not full.
- "Full" uses occupancy before any same-cycle pop, so a same-cycle pop does not free room for a push.
- A qualifying corner that is refused (FIFO full or budget reached) increments the frame drop counter. The drop counter saturates at 0xFFFF.
- Accepted and drop counters clear on the rising edge of i_image_vs. At the falling edge of i_image_vs they are copied into snapshot registers.

Output handshake:
- The FIFO head is presented through an output register.
- Once o_corner_valid is high, x, y and type hold stable until a cycle in which i_corner_ready is high.

State machine:
- IDLE → ACTIVE on a rising edge of i_image_vs.
- ACTIVE → FLUSH on a falling edge of i_image_vs. At that edge, pending = FIFO occupancy plus the output register.
- In FLUSH, each handshake decrements pending. When pending reaches 0 → DONE.
- If pending is already 0 at the falling edge, the block passes through FLUSH for one cycle, then DONE.
- DONE lasts one cycle:
  - o_frame_done is high.
  - o_corner_count and o_drop_count load from the snapshots.
  - Next state is ACTIVE if a vs rise occurred during FLUSH/DONE (pending flag), otherwise IDLE.
- Pixels of a new frame that arrive during FLUSH/DONE are pushed and counted for the new frame. The FIFO is shared across frames.

Reset mid-operation:
- Empties the FIFO, clears all counters and returns the state machine to IDLE.
- A frame in progress is abandoned; no frame-done pulse is issued for it.

## Timing

- Reset values:
  - o_corner_valid 0.
  - o_corner_x, o_corner_y, o_corner_type 0.
  - o_frame_done 0.
  - o_corner_count, o_drop_count 0.
  - o_threshold P_THRESH_INIT.
- A corner sampled at edge k is written to the FIFO at edge k. With an empty FIFO, o_corner_valid rises after edge k+1 (2-cycle latency).
- Throughput is 1 corner/cycle when i_corner_ready is held high.
- o_frame_done follows the cycle in which the last old-frame handshake occurs by exactly 1 cycle.

## Configuration

- FAST_ADAPTIVE_THRESH_EN defined — in the DONE cycle, o_threshold updates as follows:
  - drop snapshot > 0: +1, saturating at 255.
  - else accepted snapshot < P_MIN_CORNERS: −1, floor 1.
  - else: hold.
- FAST_ADAPTIVE_THRESH_EN undefined: o_threshold is constant P_THRESH_INIT.

## Test plan

- Single corner: value 1 at (5,2), ready high → o_corner_valid 2 cycles later, entry (5,2,1). After vs falls: o_frame_done, corner_count=1, drop_count=0.
- Backpressure: 20 corners with ready low → FIFO holds 16, drop_count=4, head entry held stable. Release ready → 16 entries, in order.
- Budget: P_MAX_CORNERS=3, 5 corners, ready high → 3 accepted, drop_count=2.
- Flush: vs falls with 4 entries queued, ready low for 10 cycles then high → o_frame_done 1 cycle after the 4th handshake. A new vs rise during FLUSH → state returns to ACTIVE; new-frame corners are delivered after the old ones.
- Async reset asserted mid-frame with 6 entries queued → o_corner_valid 0 immediately; no o_frame_done; counts 0.
- With FAST_ADAPTIVE_THRESH_EN:
  - Frame with 2 drops → o_threshold 3→4.
  - Next frame with 50 corners and no drops → o_threshold 4→3.
